// File: rtl/rf_exec_sequencer.sv
// Four-state execution sequencer (IDLE/READ/EXEC/WB) driving an 8-entry register file.
// Optional flag outputs are built only when RF_CTRL_FLAGS_EN is defined.
module rf_exec_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [15:0]      in_instr,
  output logic             in_ready,
  output logic [2:0]       ra1,
  output logic [2:0]       ra2,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  output logic [2:0]       wa3,
  output logic             we3,
  output logic [WIDTH-1:0] wd3,
  output logic             done,
  output logic             err,
  output logic             flag_z,
  output logic             flag_c
);

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

  state_e           state_q, state_d;
  logic [15:0]      instr_q, instr_d;
  logic [2:0]       wa3_q, wa3_d;
  logic [WIDTH-1:0] wd3_q, wd3_d;
  logic             we3_q, we3_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [3:0]       op;
  logic [2:0]       rd;
  logic [7:0]       imm8;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] alu_res;
  logic             op_legal;
  logic             lt;
  logic             write_en;

  assign op   = instr_q[15:12];
  assign rd   = instr_q[11:9];
  assign imm8 = instr_q[7:0];

  // Read addresses come straight from the latched instruction, so they stay stable
  // from READ through EXEC and hold afterwards.
  assign ra1 = instr_q[8:6];
  assign ra2 = instr_q[5:3];

  if (WIDTH >= 8) begin : g_imm_zext
    always_comb begin
      imm_ext       = '0;
      imm_ext[7:0]  = imm8;
    end
  end else begin : g_imm_trunc
    assign imm_ext = imm8[WIDTH-1:0];
  end

  assign lt = (rd1 < rd2);

  always_comb begin
    alu_res  = '0;
    op_legal = 1'b1;
    case (op)
      4'h0:    alu_res = '0;
      4'h1:    alu_res = rd1 + rd2;
      4'h2:    alu_res = rd1 - rd2;
      4'h3:    alu_res = rd1 & rd2;
      4'h4:    alu_res = rd1 | rd2;
      4'h5:    alu_res = rd1 ^ rd2;
      4'h6:    alu_res[0] = lt;
      4'h7:    alu_res = imm_ext;
      4'h8:    alu_res = rd1;
      default: op_legal = 1'b0;
    endcase
  end

  // r0 is never written; NOP and illegal opcodes retire without a write.
  assign write_en = op_legal && (op != 4'h0) && (rd != 3'd0);

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    wa3_d   = wa3_q;
    wd3_d   = wd3_q;
    we3_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          instr_d = in_instr;
          state_d = StRead;
        end
      end
      StRead: state_d = StExec;
      StExec: begin
        if (op_legal && (op != 4'h0)) begin
          wa3_d = rd;
          wd3_d = alu_res;
        end
        we3_d   = write_en;
        done_d  = 1'b1;
        err_d   = ~op_legal;
        state_d = StWb;
      end
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      instr_q <= '0;
      wa3_q   <= '0;
      wd3_q   <= '0;
      we3_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      wa3_q   <= wa3_d;
      wd3_q   <= wd3_d;
      we3_q   <= we3_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign in_ready = (state_q == StIdle);
  assign wa3      = wa3_q;
  assign wd3      = wd3_q;
  assign we3      = we3_q;
  assign done     = done_q;
  assign err      = err_q;

`ifdef RF_CTRL_FLAGS_EN
  logic [WIDTH:0] sum_w;
  logic           flag_upd;
  logic           carry;
  logic           flag_z_q, flag_c_q;

  assign sum_w = {1'b0, rd1} + {1'b0, rd2};

  always_comb begin
    flag_upd = 1'b0;
    carry    = 1'b0;
    case (op)
      4'h1:                      begin flag_upd = 1'b1; carry = sum_w[WIDTH]; end
      4'h2:                      begin flag_upd = 1'b1; carry = lt;           end
      4'h3, 4'h4, 4'h5, 4'h6:    flag_upd = 1'b1;
      default:                   flag_upd = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else if ((state_q == StExec) && flag_upd) begin
      flag_z_q <= (alu_res == '0);
      flag_c_q <= carry;
    end
  end

  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
`else
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
`endif

endmodule

// File: tb/tb_rf_exec_sequencer.sv
// Directed bench for rf_exec_sequencer: per-cycle comparison against a transaction-level
// model plus literal expectations for each directed instruction.
module tb_rf_exec_sequencer;

  localparam int W   = 8;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [15:0]  in_instr;
  logic         in_ready;
  logic [2:0]   ra1, ra2, wa3;
  logic [W-1:0] rd1, rd2, wd3;
  logic         we3, done, err, flag_z, flag_c;

  logic [W-1:0] rf [8];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  rf_exec_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_instr (in_instr),
    .in_ready (in_ready),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .wa3      (wa3),
    .we3      (we3),
    .wd3      (wd3),
    .done     (done),
    .err      (err),
    .flag_z   (flag_z),
    .flag_c   (flag_c)
  );

  // Register file environment
  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];
  always @(posedge clk) if (we3 === 1'b1) rf[wa3] <= wd3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int         cyc = 0;
  bit         armed = 0;
  int         idle_from = 0;
  bit         p_valid = 0;
  int         p_wb;
  bit         p_we, p_err, p_fupd, p_z, p_c;
  logic [2:0] p_wa, p_rs1, p_rs2;
  logic [W-1:0] p_wd;
  bit         m_z = 0, m_c = 0;
  logic [W-1:0] model_rf [8];
  int         acc_log [$];

  always @(posedge clk) begin
    if (rst) begin
      armed     = 1;
      p_valid   = 0;
      m_z       = 0;
      m_c       = 0;
      idle_from = cyc + 1;
    end else if (armed) begin
      if (p_valid && cyc == p_wb - 1 && p_fupd) begin
        m_z = p_z;
        m_c = p_c;
      end
      if (p_valid && cyc == p_wb) begin
        if (p_we) model_rf[p_wa] = p_wd;
        p_valid = 0;
      end
      if (in_valid && cyc >= idle_from) begin
        int op, a, b, r, rdn;
        bit legal, c, upd;
        op  = int'(in_instr[15:12]);
        rdn = int'(in_instr[11:9]);
        p_rs1 = in_instr[8:6];
        p_rs2 = in_instr[5:3];
        a = int'(model_rf[p_rs1]);
        b = int'(model_rf[p_rs2]);
        r = 0; c = 0; upd = 0; legal = 1;
        case (op)
          0: r = 0;
          1: begin r = a + b; c = (r >= MOD); r = r % MOD; upd = 1; end
          2: begin r = (a - b + MOD) % MOD; c = (a < b); upd = 1; end
          3: begin r = a & b; upd = 1; end
          4: begin r = a | b; upd = 1; end
          5: begin r = a ^ b; upd = 1; end
          6: begin r = (a < b) ? 1 : 0; upd = 1; end
          7: r = int'(in_instr[7:0]) % MOD;
          8: r = a;
          default: legal = 0;
        endcase
        p_valid   = 1;
        p_wb      = cyc + 3;
        idle_from = cyc + 4;
        p_we      = legal && op != 0 && rdn != 0;
        p_err     = !legal;
        p_wa      = 3'(rdn);
        p_wd      = W'(r);
        p_fupd    = upd;
        p_z       = (r == 0);
        p_c       = c;
        acc_log.push_back(cyc);
      end
    end
    cyc = cyc + 1;
  end

  function automatic bit exp_flag(input bit v);
`ifdef RF_CTRL_FLAGS_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (armed) begin
      bit wb;
      wb = p_valid && (cyc == p_wb);
      chk("in_ready", in_ready, cyc >= idle_from);
      chk("done", done, wb);
      chk("err", err, wb && p_err);
      chk("we3", we3, wb && p_we);
      if (wb && p_we) begin
        chk("wa3", wa3, p_wa);
        chk("wd3", wd3, p_wd);
      end
      if (p_valid && (cyc == p_wb - 2 || cyc == p_wb - 1)) begin
        chk("ra1", ra1, p_rs1);
        chk("ra2", ra2, p_rs2);
      end
      chk("flag_z", flag_z, exp_flag(m_z));
      chk("flag_c", flag_c, exp_flag(m_c));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(input logic [15:0] ins, input bit e_we, input logic [2:0] e_wa,
                       input logic [W-1:0] e_wd, input bit e_err, input bit ck_flags,
                       input bit e_z, input bit e_c);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = ins;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 8);
    chk("latency", n, 3);
    chk("lit_we3", we3, e_we);
    chk("lit_err", err, e_err);
    if (e_we) begin
      chk("lit_wa3", wa3, e_wa);
      chk("lit_wd3", wd3, e_wd);
    end
    if (ck_flags) begin
      chk("lit_flag_z", flag_z, exp_flag(e_z));
      chk("lit_flag_c", flag_c, exp_flag(e_c));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] stream [3];
    int n;
    for (int i = 0; i < 8; i++) begin
      rf[i]       = '0;
      model_rf[i] = '0;
    end
    rst      = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ra1", ra1, 0);
    chk("rst_ra2", ra2, 0);
    chk("rst_wa3", wa3, 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_flags", {flag_z, flag_c}, 2'b00);

    issue(16'h7205, 1, 3'd1, 8'h05, 0, 0, 0, 0);        // LDI r1,05
    issue(16'h7403, 1, 3'd2, 8'h03, 0, 0, 0, 0);        // LDI r2,03
    chk("rf1_lit", rf[1], 8'h05);
    issue(16'h72FF, 1, 3'd1, 8'hFF, 0, 0, 0, 0);        // LDI r1,FF
    issue(16'h7401, 1, 3'd2, 8'h01, 0, 0, 0, 0);        // LDI r2,01
    issue(16'h1650, 1, 3'd3, 8'h00, 0, 1, 1, 1);        // ADD r3,r1,r2
    issue(16'h8EC0, 1, 3'd7, 8'h00, 0, 1, 1, 1);        // MOV r7,r3 keeps flags
    issue(16'h7205, 1, 3'd1, 8'h05, 0, 0, 0, 0);
    issue(16'h7403, 1, 3'd2, 8'h03, 0, 0, 0, 0);
    issue(16'h2888, 1, 3'd4, 8'hFE, 0, 1, 0, 1);        // SUB r4,r2,r1
    issue(16'h6A88, 1, 3'd5, 8'h01, 0, 1, 0, 0);        // SLTU r5,r2,r1
    issue(16'h3C50, 1, 3'd6, 8'h01, 0, 1, 0, 0);        // AND
    issue(16'h4E50, 1, 3'd7, 8'h07, 0, 1, 0, 0);        // OR
    issue(16'h5C50, 1, 3'd6, 8'h06, 0, 1, 0, 0);        // XOR
    issue(16'h70AA, 0, 3'd0, 8'h00, 0, 0, 0, 0);        // LDI r0 -> no write
    issue(16'hF000, 0, 3'd0, 8'h00, 1, 0, 0, 0);        // illegal
    issue(16'h0000, 0, 3'd0, 8'h00, 0, 0, 0, 0);        // NOP
    @(posedge clk);
    #1 chk("rf0_never_written", rf[0], 8'h00);

    // Held in_valid with three queued, dependent instructions
    stream[0] = 16'h7210;                               // LDI r1,10
    stream[1] = 16'h1448;                               // ADD r2,r1,r1
    stream[2] = 16'h2688;                               // SUB r3,r2,r1
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = stream[i];
      n = 0;
      while (in_ready !== 1'b1 && n < 8) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    if (acc_log.size() >= 3) begin
      chk("accept_spacing_a", acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2], 4);
      chk("accept_spacing_b", acc_log[acc_log.size()-2] - acc_log[acc_log.size()-3], 4);
    end else begin
      chk("accept_count", acc_log.size(), 3);
    end
    @(posedge clk);
    #1;
    chk("rf2_stream", rf[2], 8'h20);
    chk("rf3_stream", rf[3], 8'h10);

    issue(16'h2850, 1, 3'd4, 8'hF0, 0, 1, 0, 1);        // SUB r4,r1,r2 borrow

    // Reset during EXEC of ADD r3,r1,r2 aborts it
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = 16'h1650;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_done", done, 0);
    chk("abort_flags", {flag_z, flag_c}, 2'b00);
    repeat (5) @(negedge clk);
    chk("abort_rf3", rf[3], 8'h10);
    chk("abort_rf4", rf[4], 8'hF0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/rf_exec_sequencer.md
Name: rf_exec_sequencer

Overview:
- Multicycle execution sequencer sitting directly upstream of the 8-entry register file.
- Accepts one 16-bit instruction per valid/ready handshake and drives the register file read ports (ra1/ra2).
- Captures rd1/rd2, computes an ALU result, then drives the write port (wa3/we3/wd3) for one cycle.
- Provides the register file's only write path in the datapath.

Parameters:
- WIDTH, 8, data width of register file entries, ALU operands and wd3.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  instruction available.
- in_instr  in  16  instruction word.
- in_ready  out  1  sequencer can accept an instruction.
- ra1  out  3  register file read address 1.
- ra2  out  3  register file read address 2.
- rd1  in  WIDTH  register file read data 1 (combinational from ra1).
- rd2  in  WIDTH  register file read data 2 (combinational from ra2).
- wa3  out  3  register file write address.
- we3  out  1  register file write enable.
- wd3  out  WIDTH  register file write data.
- done  out  1  one-cycle pulse, instruction retired.
- err  out  1  one-cycle pulse, illegal opcode retired.
- flag_z  out  1  result == 0 flag.
- flag_c  out  1  carry/borrow flag.

Behaviour:
- Reset is synchronous, active-high, with one clock; rst has priority over every other input.
- Reset values: state=IDLE, ra1=ra2=wa3=0, we3=0, wd3=0, done=0, err=0, flag_z=0, flag_c=0. in_ready=1 from the first cycle after reset.
- rst asserted mid-instruction aborts it: no write occurs and no done pulse is produced.
- Instruction fields: op=[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3], imm8=[7:0].
  - imm8 is zero-extended to WIDTH, or truncated to its low WIDTH bits when WIDTH<8.
- Opcodes:
  - 0 NOP: no write.
  - 1 ADD: rs1+rs2.
  - 2 SUB: rs1-rs2.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 SLTU: result=1 if rs1<rs2 unsigned, else 0.
  - 7 LDI: result=imm8.
  - 8 MOV: result=rs1.
  - 9-15 illegal: no write, err pulses with done.
- All arithmetic is WIDTH bits and wraps modulo 2^WIDTH.
  - ADD: carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB: carry = borrow (1 when rs1<rs2).
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE: in_ready=1. When in_valid=1, latch in_instr and go to READ. in_valid while not IDLE is ignored (in_ready=0).
  - READ: ra1=rs1, ra2=rs2 held stable. Go to EXEC.
  - EXEC: capture rd1/rd2, compute result into a WIDTH-bit register, update flags. Go to WB.
  - WB: we3=1, wa3=rd, wd3=result for exactly one cycle; done=1. Go to IDLE.
- we3 is suppressed (held 0) in WB when rd==0 or op is NOP/illegal; done still pulses.
- Register r0 therefore never receives a write from this block.
- Latency: handshake at edge T, done/we3 high in cycle T+3, in_ready high again at T+4. Throughput is 1 instruction per 4 cycles.
- Back-to-back dependency (write rd, then read the same reg) is safe: the write commits at the end of WB, before the next READ.
- Flags update only in EXEC of ADD/SUB/AND/OR/XOR/SLTU and hold otherwise.
  - flag_z = (result==0).
  - flag_c is cleared by logic ops and SLTU.
- Outputs are held at their last values when not in their active state. we3, done and err are 0 outside WB.

Optional Feature:
- Macro RF_CTRL_FLAGS_EN.
- Defined: flag_z/flag_c behave as above.
- Undefined: flag logic is not built; flag_z and flag_c are tied to 0. All other behaviour is identical.

Test Plan:
- Reset, then LDI r1,0x05 (0x7205) and LDI r2,0x03 (0x7403) -> we3 pulses with wa3=1/wd3=0x05, then wa3=2/wd3=0x03; done at T+3 after each accept.
- ADD r3,r1,r2 (0x1650) with r1=0xFF, r2=0x01 -> wd3=0x00, wa3=3, flag_z=1, flag_c=1.
- SUB r4,r2,r1 (0x2888) with r2=0x03, r1=0x05 -> wd3=0xFE, flag_c=1, flag_z=0. SLTU r5,r2,r1 -> wd3=0x01.
- LDI r0,0xAA (0x70AA) -> done=1, we3 stays 0. Opcode 0xF -> err=1 and done=1 same cycle, no write.
- Hold in_valid high with 3 instructions queued -> exactly one accept per 4 cycles; in_ready=0 in READ/EXEC/WB.
- Assert rst during EXEC of ADD -> no we3/done; in_ready=1 the cycle after rst drops; flags=0.
